// File: rtl/serial_subtractor.sv
`default_nettype none
//==============================================================================
// Module     : serial_subtractor
// Description: Bit-serial D = A - B - Bin, LSB first, one bit per clock, with a
//              start/done handshake. Define SERIAL_SUB_OVF_EN to add the
//              two's-complement overflow output V.
// Revision   : 1.0 - initial release
//==============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;

    // Full-subtractor cell on the current LSBs and the borrow register.
    assign w_a       = r_a_sh[0];
    assign w_b       = r_b_sh[0];
    assign w_d       = w_a ^ w_b ^ r_br;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

    assign busy = (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == c_LAST_IDX) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Borrow entering the MSB cell, remembered for the overflow flag.
    logic r_br_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_msb <= 1'b0;
            V        <= 1'b0;
        end else begin
            if (r_state == S_SHIFT) r_br_msb <= r_br;
            if (r_state == S_DONE)  V        <= r_br ^ r_br_msb;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_d_sh <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
        end else begin
            done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh <= A;
                        r_b_sh <= B;
                        r_br   <= Bin;
                        r_d_sh <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_d_sh <= {w_d, r_d_sh[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    D    <= r_d_sh;
                    Bout <= r_br;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
